bcd_conv_arbiter: RTL and testbench

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_conv_arbiter.sv | 125 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Two-requester binary-to-BCD converter: arbitrates between requesters, runs an
// 8-step double-dabble on the winner's operand and holds the result until accepted.
module bcd_conv_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] bin0,
    input  logic [7:0] bin1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_id,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        last_gnt;
    logic        winner;
    logic        owner;
    logic [7:0]  operand;
    logic [3:0]  dig_h;
    logic [3:0]  dig_t;
    logic [3:0]  dig_o;
    logic [2:0]  cnt;
    logic [19:0] adjusted;
    logic [19:0] step;

    function automatic logic [3:0] adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Round-robin favours whoever was not granted last; fixed priority favours 0
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = (RR_EN != 0) ? ~last_gnt : 1'b0;
            default: winner = 1'b0;
        endcase
    end

    always_comb begin
        adjusted = {adj(dig_h), adj(dig_t), adj(dig_o), operand};
        step     = {adjusted[18:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (req != 2'b00) next_state = CONV;
            CONV:    if (cnt == 3'd7) next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: the 8th step result is written straight into the output digits
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= 2'b00;
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            operand   <= 8'd0;
            dig_h     <= 4'd0;
            dig_t     <= 4'd0;
            dig_o     <= 4'd0;
            cnt       <= 3'd0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            bcd0      <= 4'd0;
            bcd1      <= 4'd0;
            bcd2      <= 4'd0;
        end else begin
            gnt <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt      <= winner ? 2'b10 : 2'b01;
                        last_gnt <= winner;
                        owner    <= winner;
                        operand  <= winner ? bin1 : bin0;
                        dig_h    <= 4'd0;
                        dig_t    <= 4'd0;
                        dig_o    <= 4'd0;
                        cnt      <= 3'd0;
                    end
                end
                CONV: begin
                    {dig_h, dig_t, dig_o, operand} <= step;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bcd2      <= step[19:16];
                        bcd1      <= step[15:12];
                        bcd0      <= step[11:8];
                        out_valid <= 1'b1;
                        out_id    <= owner;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: a round-robin and a fixed-priority
// instance share stimulus; expected results flow through a scoreboard queue.
module tb_bcd_conv_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] bin0;
    logic [7:0] bin1;
    logic       out_ready;

    logic [1:0] gnt;
    logic       busy;
    logic       out_valid;
    logic       out_id;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;

    logic [1:0] fp_gnt;
    logic       fp_busy;
    logic       fp_out_valid;
    logic       fp_out_id;
    logic [3:0] fp_bcd0;
    logic [3:0] fp_bcd1;
    logic [3:0] fp_bcd2;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [12:0] sb[$];
    logic [11:0] last_bcd = 12'd0;

    bcd_conv_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst), .req(req), .bin0(bin0), .bin1(bin1),
        .gnt(gnt), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2)
    );

    bcd_conv_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .bin0(bin0), .bin1(bin1),
        .gnt(fp_gnt), .busy(fp_busy), .out_valid(fp_out_valid), .out_ready(out_ready),
        .out_id(fp_out_id), .bcd0(fp_bcd0), .bcd1(fp_bcd1), .bcd2(fp_bcd2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_bcd = 12'd0;
    endtask

    // Raise one request, wait for its grant and confirm the old result is still held
    task automatic applyStimulus(input logic id, input logic [7:0] v);
        int n;
        sb.push_back({id, to_bcd(int'(v))});
        if (id) bin1 = v;
        else    bin0 = v;
        req[id] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < 30);
        check("gnt", 32'(gnt), id ? 32'd2 : 32'd1);
        check("retain", 32'({bcd2, bcd1, bcd0}), 32'(last_bcd));
        req[id] = 1'b0;
    endtask

    // Called right after a grant is observed: expects out_valid 8 edges later
    task automatic checkOutput();
        int n;
        logic [12:0] exp;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd8);
        exp = sb.pop_front();
        check("result", 32'({out_id, bcd2, bcd1, bcd0}), 32'(exp));
        last_bcd = exp[11:0];
    endtask

    task automatic doConv(input logic id, input logic [7:0] v);
        applyStimulus(id, v);
        checkOutput();
        tick();
        check("release", 32'({out_valid, busy}), 32'd0);
    endtask

    initial begin
        int          n;
        int          prev;
        logic [1:0]  expg;
        logic        seen;

        rst = 1'b1;
        req = 2'b00;
        bin0 = 8'd0;
        bin1 = 8'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_rr", 32'({gnt, busy, out_valid, out_id, bcd2, bcd1, bcd0}), 32'd0);
        check("reset_fp", 32'({fp_gnt, fp_busy, fp_out_valid, fp_out_id, fp_bcd2, fp_bcd1, fp_bcd0}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_no_gnt", 32'({gnt, busy}), 32'd0);

        doConv(1'b0, 8'd255);
        doConv(1'b1, 8'd0);
        doConv(1'b1, 8'd100);
        doConv(1'b1, 8'd99);

        // Contention from a fresh reset: requester 0 wins first, then alternation
        pulseReset();
        bin0 = 8'd42;
        bin1 = 8'd217;
        req = 2'b11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt == 2'b00 && n < 30) begin
                tick();
                n++;
            end
            expg = (k % 2 == 1) ? 2'b10 : 2'b01;
            check("rr_gnt", 32'(gnt), 32'(expg));
            check("fp_gnt", 32'(fp_gnt), 32'd1);
            if (k > 0) check("rr_spacing", 32'(cyc - prev), 32'd10);
            prev = cyc;
            sb.push_back({expg[1], to_bcd(expg[1] ? 217 : 42)});
            checkOutput();
            check("fp_id", 32'(fp_out_id), 32'd0);
            tick();
        end
        req = 2'b00;

        // Back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        applyStimulus(1'b0, 8'd173);
        checkOutput();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold", 32'({out_valid, busy, out_id, bcd2, bcd1, bcd0}), 32'({1'b1, 1'b1, 1'b0, 12'h173}));
        end
        out_ready = 1'b1;
        tick();
        check("handshake", 32'({out_valid, busy}), 32'd0);

        // Reset in the middle of a conversion
        bin0 = 8'd200;
        req = 2'b01;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < 30);
        check("abort_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_bcd = 12'd0;
        check("abort", 32'({busy, out_valid, gnt, out_id, bcd2, bcd1, bcd0}), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | out_valid | (gnt != 2'b00);
        end
        check("no_replay", 32'(seen), 32'd0);
        doConv(1'b0, 8'd58);

        for (int v = 0; v < 256; v++) doConv(1'b0, 8'(v));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
